// File: rtl/rgmii_pkg.sv
// Shared RGMII receive definitions: FSM states, framing constants and the
// byte-wide reflected CRC-32 step.
package rgmii_pkg;

  typedef enum logic [2:0] {IDLE, PRE, HDR, PAY, FCS, DROP} state_t;

  localparam logic [7:0]  PREAMBLE    = 8'h55;
  localparam logic [7:0]  SFD         = 8'hd5;
  localparam logic [31:0] CRC_POLY    = 32'hedb88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hdebb20e3;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/rgmii_ddr_in.sv
// RGMII DDR capture: rebuilds one byte per clock with its valid and line-error flags.
module rgmii_ddr_in
  import rgmii_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxctl,
  input  logic [3:0] rxd,
  output logic [7:0] data,
  output logic       bv,
  output logic       er
);

  logic [3:0] lo, hi;
  logic       dv, ctl_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo <= '0;
      dv <= 1'b0;
    end else begin
      lo <= rxd;
      dv <= rxctl;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi    <= '0;
      ctl_n <= 1'b0;
    end else begin
      hi    <= rxd;
      ctl_n <= rxctl;
    end
  end

  // Falling-edge half joins the rising-edge half one clock later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      bv   <= 1'b0;
      er   <= 1'b0;
    end else begin
      data <= {hi, lo};
      bv   <= dv;
      er   <= dv ^ ctl_n;
    end
  end

endmodule

// File: rtl/rgmii_frame_rx.sv
// RGMII frame receiver: header filter, payload write into a two-bank buffer,
// FCS check, and publish of the bank holding the last good frame.
module rgmii_frame_rx
  import rgmii_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR    = 48'h0088_dab8_bf08,
  parameter logic [15:0] ETHERTYPE   = 16'h1919,
  parameter int          PAYLOAD_LEN = 1024,
  parameter int          AW          = 10
) (
  input  logic          clk125,
  input  logic          rst_n,
  input  logic          rxctl,
  input  logic [3:0]    rxd,
  output logic          wr_en,
  output logic [AW:0]   wr_ad,
  output logic [7:0]    wr_data,
  output logic          idx,
  output logic [15:0]   seq,
  output logic          frame_ok,
  output logic          frame_err,
  output logic [15:0]   err_cnt
);

  localparam int BW = AW + 1;
  localparam logic [BW-1:0] HDR_LAST  = BW'(15);
  localparam logic [BW-1:0] PAY_LAST  = BW'(PAYLOAD_LEN + 15);
  localparam logic [BW-1:0] FRAME_LEN = BW'(PAYLOAD_LEN + 20);

  logic [7:0]    data;
  logic          bv, er;
  state_t        state, state_nxt;
  logic [BW-1:0] bcnt;
  logic [31:0]   crc;
  logic [15:0]   shadow;
  logic          wbank;
  logic [AW-1:0] off;
  logic          take, frame_end, drop_end, hdr_bad, good, bad, sfd;

  rgmii_ddr_in u_ddr (
    .clk   (clk125),
    .rst_n (rst_n),
    .rxctl (rxctl),
    .rxd   (rxd),
    .data  (data),
    .bv    (bv),
    .er    (er)
  );

  assign off  = AW'(bcnt - BW'(16));
  assign sfd  = (state == PRE) && bv && (data == SFD);
  assign good = frame_end && (bcnt == FRAME_LEN) && (crc == CRC_RESIDUE);
  assign bad  = drop_end || (frame_end && !good);

  always_comb begin
    hdr_bad = 1'b0;
    if (state == HDR) begin
      if (bcnt < BW'(6))        hdr_bad = data != 8'(MAC_ADDR >> {bcnt[2:0], 3'b000});
      else if (bcnt == BW'(12)) hdr_bad = data != ETHERTYPE[15:8];
      else if (bcnt == BW'(13)) hdr_bad = data != ETHERTYPE[7:0];
    end
  end

  always_ff @(posedge clk125 or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    frame_end = 1'b0;
    drop_end  = 1'b0;
    case (state)
      IDLE: if (bv && data == PREAMBLE) state_nxt = PRE;
      PRE: begin
        if (!bv)                    state_nxt = IDLE;
        else if (data == SFD)       state_nxt = HDR;
        else if (data != PREAMBLE)  state_nxt = IDLE;
      end
      HDR, PAY, FCS: begin
        if (!bv) begin
          state_nxt = IDLE;
          frame_end = 1'b1;
        end else if (er || hdr_bad || bcnt == FRAME_LEN) begin
          state_nxt = DROP;
        end else begin
          take = 1'b1;
          if (state == HDR && bcnt == HDR_LAST) state_nxt = PAY;
          if (state == PAY && bcnt == PAY_LAST) state_nxt = FCS;
        end
      end
      DROP: begin
        if (!bv) begin
          state_nxt = IDLE;
          drop_end  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk125 or negedge rst_n) begin
    if (!rst_n) begin
      bcnt      <= '0;
      crc       <= 32'hffff_ffff;
      shadow    <= '0;
      wbank     <= 1'b1;
      wr_en     <= 1'b0;
      wr_ad     <= '0;
      wr_data   <= '0;
      idx       <= 1'b0;
      seq       <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_cnt   <= '0;
    end else begin
      if (sfd) begin
        bcnt <= '0;
        crc  <= 32'hffff_ffff;
      end else if (take) begin
        bcnt <= bcnt + BW'(1);
        crc  <= crc32_byte(crc, data);
        if (bcnt == BW'(14)) shadow[7:0]  <= data;
        if (bcnt == BW'(15)) shadow[15:8] <= data;
      end
      wr_en <= take && (state == PAY);
      if (take && state == PAY) begin
        wr_ad   <= {wbank, off};
        wr_data <= data;
      end
      frame_ok  <= good;
      frame_err <= bad;
      // Only a good frame flips banks, so a bad one is overwritten by the next
      if (good) begin
        idx   <= wbank;
        wbank <= ~wbank;
        seq   <= shadow;
      end
      if (bad && err_cnt != 16'hffff) err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule
